// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types for the in-order RISC-V core: the shadow-entry
// record tracked by the hazard controller, the forward-select encoding and
// the instruction-type constants used by the decoder and execute stage.
package rv_pipe_pkg;

  // Field widths inside a shadow entry. They are sized generously so that
  // any legal REG_W / DEPTH choice of the hazard controller fits.
  localparam int RD_MAX_W = 8;
  localparam int AVAIL_W  = 4;

  // One in-flight producer: does it write a register, which one, and the
  // first shadow stage at which its result can be forwarded.
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic [AVAIL_W-1:0]  avail;
  } shadow_entry_t;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Instruction classes shared by decoder and execute.
  localparam logic [1:0] IS_ADD   = 2'd0;
  localparam logic [1:0] IS_LOAD  = 2'd1;
  localparam logic [1:0] IS_STORE = 2'd2;

  // Forwarding availability stage of a newly issued instruction.
  function automatic logic [AVAIL_W-1:0] avail_for(input logic is_load,
                                                   input int   alu_avail,
                                                   input int   load_avail);
    return is_load ? AVAIL_W'(load_avail) : AVAIL_W'(alu_avail);
  endfunction

endpackage

// File: rtl/rv_src_match.sv
// Priority search of one source operand against the shadow pipeline.
// The youngest (lowest-stage) producer of the register wins; the source
// stalls when that producer's result is not yet forwardable.
module rv_src_match
  import rv_pipe_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int DEPTH = 4,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic          src_en,
  input  logic [REG_W-1:0] src_idx,
  input  shadow_entry_t ent [DEPTH],
  output logic          hit,
  output logic [SEL_W-1:0] stage,
  output logic          stall
);

  // Scan oldest to youngest so the youngest matching entry overwrites last.
  always_comb begin
    hit   = 1'b0;
    stage = SEL_W'(FWD_RF);
    stall = 1'b0;
    if (src_en && (src_idx != '0)) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (ent[i].valid && (ent[i].rd == RD_MAX_W'(src_idx))) begin
          hit   = 1'b1;
          stage = SEL_W'(i + 1);
          stall = (AVAIL_W'(i + 1) < ent[i].avail);
        end
      end
    end
  end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Hazard control for the in-order pipeline: tracks in-flight destination
// registers in a shadow pipeline and, for the instruction at issue, decides
// whether to stall or which stage to forward each source operand from.
//
// Handshake: issue_valid marks an instruction at decode; when issue_stall is
// high that instruction is not accepted and must be presented again; an
// instruction is accepted on a clock edge where issue_valid=1, issue_stall=0
// and flush=0. A flush squashes the presented instruction unconditionally.
module rv_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 4,
  parameter int ALU_AVAIL  = 1,
  parameter int LOAD_AVAIL = 2,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         issue_rs1e,
  input  logic [REG_W-1:0]             issue_rs1,
  input  logic                         issue_rs2e,
  input  logic [REG_W-1:0]             issue_rs2,
  input  logic                         issue_rde,
  input  logic [REG_W-1:0]             issue_rd,
  input  logic                         issue_is_load,
  input  logic                         flush,
  output logic                         issue_stall,
  output logic [SEL_W-1:0]             fwd_sel_rs1,
  output logic [SEL_W-1:0]             fwd_sel_rs2,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_cnt,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int CNT_IW = $clog2(DEPTH + 1);

  // ent_q[i] is shadow stage i+1 (stage 1 = execute).
  shadow_entry_t ent_q [DEPTH];
  shadow_entry_t ent_d [DEPTH];

  logic              rs1_hit, rs1_stall;
  logic              rs2_hit, rs2_stall;
  logic [SEL_W-1:0]  rs1_stage, rs2_stage;
  logic              accept;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;
  logic [CNT_IW-1:0] inflight_q;
  logic [CNT_IW-1:0] inflight_d;

  rv_src_match #(
    .REG_W (REG_W),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match_rs1 (
    .src_en  (issue_rs1e),
    .src_idx (issue_rs1),
    .ent     (ent_q),
    .hit     (rs1_hit),
    .stage   (rs1_stage),
    .stall   (rs1_stall)
  );

  rv_src_match #(
    .REG_W (REG_W),
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match_rs2 (
    .src_en  (issue_rs2e),
    .src_idx (issue_rs2),
    .ent     (ent_q),
    .hit     (rs2_hit),
    .stage   (rs2_stage),
    .stall   (rs2_stall)
  );

  // Stall decision and operand-forward selects for the presented instruction.
  // A flush squashes the instruction anyway, so it never stalls.
  always_comb begin
    issue_stall = issue_valid && !flush && (rs1_stall || rs2_stall);
    accept      = issue_valid && !issue_stall && !flush;
    fwd_sel_rs1 = SEL_W'(FWD_RF);
    fwd_sel_rs2 = SEL_W'(FWD_RF);
    if (issue_valid && !issue_stall) begin
      if (rs1_hit && !rs1_stall) fwd_sel_rs1 = rs1_stage;
      if (rs2_hit && !rs2_stall) fwd_sel_rs2 = rs2_stage;
    end
  end

  // Next shadow contents: shift every stage down, squash the stages younger
  // than the branch on a flush, and load stage 1 with the accepted issue.
  always_comb begin
    ent_d[0].valid = accept && issue_rde && (issue_rd != '0);
    ent_d[0].rd    = RD_MAX_W'(issue_rd);
    ent_d[0].avail = avail_for(issue_is_load, ALU_AVAIL, LOAD_AVAIL);
    for (int i = 1; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i-1];
      // ent_q[i-1] sits at stage i; stages below BR_STAGE are wrong-path.
      if (flush && (i < BR_STAGE)) ent_d[i].valid = 1'b0;
    end
  end

  // Population count of the next shadow valids, registered as inflight_cnt.
  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      inflight_d = inflight_d + CNT_IW'(ent_d[i].valid);
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers; reset drops all tracked producers without retiring them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      stall_cnt_q <= '0;
      inflight_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      stall_cnt_q <= stall_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign inflight_cnt = inflight_q;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Testbench for rv_hazard_ctrl: directed scenarios plus random traffic,
// checked against a list-of-producers reference model.
module tb_rv_hazard_ctrl;

  localparam int REG_W      = 5;
  localparam int DEPTH      = 4;
  localparam int ALU_AVAIL  = 1;
  localparam int LOAD_AVAIL = 2;
  localparam int BR_STAGE   = 2;
  localparam int CNT_W      = 4;
  localparam int SEL_W      = $clog2(DEPTH + 1);
  localparam int W          = 1 + 3 * SEL_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             issue_valid, issue_rs1e, issue_rs2e, issue_rde, issue_is_load, flush;
  logic [REG_W-1:0] issue_rs1, issue_rs2, issue_rd;
  logic             issue_stall;
  logic [SEL_W-1:0] fwd_sel_rs1, fwd_sel_rs2, inflight_cnt;
  logic [CNT_W-1:0] stall_cnt;

  rv_hazard_ctrl #(
    .REG_W (REG_W), .DEPTH (DEPTH), .ALU_AVAIL (ALU_AVAIL),
    .LOAD_AVAIL (LOAD_AVAIL), .BR_STAGE (BR_STAGE), .CNT_W (CNT_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk (clk), .reset (reset),
    .issue_valid (issue_valid), .issue_rs1e (issue_rs1e), .issue_rs1 (issue_rs1),
    .issue_rs2e (issue_rs2e), .issue_rs2 (issue_rs2), .issue_rde (issue_rde),
    .issue_rd (issue_rd), .issue_is_load (issue_is_load), .flush (flush),
    .issue_stall (issue_stall), .fwd_sel_rs1 (fwd_sel_rs1), .fwd_sel_rs2 (fwd_sel_rs2),
    .inflight_cnt (inflight_cnt), .stall_cnt (stall_cnt)
  );

  // ---------------- reference model ----------------
  // Producers in flight, each with its current stage (1 = execute).
  typedef struct {
    int rd;
    int avail;
    int stage;
  } prod_t;

  prod_t prods[$];
  int    m_stall_cnt;

  // Forward stage for a source, or -1 if it must stall, 0 if register file.
  function automatic int src_lookup(input logic en, input int idx);
    int best_stage = DEPTH + 1;
    int best_avail = 0;
    if (!en || idx == 0) return 0;
    foreach (prods[i]) begin
      if (prods[i].rd == idx && prods[i].stage < best_stage) begin
        best_stage = prods[i].stage;
        best_avail = prods[i].avail;
      end
    end
    if (best_stage > DEPTH) return 0;
    if (best_stage >= best_avail) return best_stage;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are sampled 2 time units after the falling edge on
  // which the driver presented inputs.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue_stall",  int'(issue_stall),  int'(e[W-1]));
        check("fwd_sel_rs1",  int'(fwd_sel_rs1),  int'(e[W-2 -: SEL_W]));
        check("fwd_sel_rs2",  int'(fwd_sel_rs2),  int'(e[W-2-SEL_W -: SEL_W]));
        check("inflight_cnt", int'(inflight_cnt), int'(e[CNT_W+SEL_W-1 -: SEL_W]));
        check("stall_cnt",    int'(stall_cnt),    int'(e[CNT_W-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle of stimulus: drive, push the expected response, advance model.
  task automatic issue(input logic v, input logic r1e, input int r1,
                       input logic r2e, input int r2, input logic rde,
                       input int rd, input logic ld, input logic fl);
    int s1, s2, e_sel1, e_sel2;
    logic e_stall;
    prod_t p;
    prod_t kept[$];
    @(negedge clk);
    issue_valid = v;  issue_rs1e = r1e; issue_rs1 = REG_W'(r1);
    issue_rs2e = r2e; issue_rs2 = REG_W'(r2);
    issue_rde = rde;  issue_rd = REG_W'(rd);
    issue_is_load = ld; flush = fl;

    s1 = src_lookup(r1e, r1);
    s2 = src_lookup(r2e, r2);
    e_stall = v && !fl && (s1 < 0 || s2 < 0);
    e_sel1 = (v && !e_stall && s1 > 0) ? s1 : 0;
    e_sel2 = (v && !e_stall && s2 > 0) ? s2 : 0;
    exp_q.push_back({e_stall, SEL_W'(e_sel1), SEL_W'(e_sel2),
                     SEL_W'(prods.size()), CNT_W'(m_stall_cnt)});

    // Model advance for the coming clock edge.
    if (e_stall && m_stall_cnt < (1 << CNT_W) - 1) m_stall_cnt++;
    foreach (prods[i]) begin
      p = prods[i];
      if (fl && p.stage < BR_STAGE) continue;
      p.stage++;
      if (p.stage <= DEPTH) kept.push_back(p);
    end
    prods = kept;
    if (v && !e_stall && !fl && rde && rd != 0) begin
      p.rd = rd; p.avail = ld ? LOAD_AVAIL : ALU_AVAIL; p.stage = 1;
      prods.push_front(p);
    end
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    issue_valid = 0; issue_rs1e = 0; issue_rs2e = 0; issue_rde = 0;
    issue_is_load = 0; flush = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    repeat (2) @(negedge clk);
    prods.delete();
    m_stall_cnt = 0;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    m_stall_cnt = 0;
    do_reset();
    idle();                                  // reset state
    // add x5 ; add x6,x5,x1 -> forward from stage 1
    issue(1, 0, 0, 0, 0, 1, 5, 0, 0);
    issue(1, 1, 5, 1, 1, 1, 6, 0, 0);
    idle(); idle(); idle(); idle();
    // lw x5 ; add x6,x5,x5 -> one stall then forward from stage 2
    issue(1, 0, 0, 0, 0, 1, 5, 1, 0);
    issue(1, 1, 5, 1, 5, 1, 6, 0, 0);
    issue(1, 1, 5, 1, 5, 1, 6, 0, 0);
    idle(); idle(); idle(); idle();
    // write to x0, then read x0
    issue(1, 0, 0, 0, 0, 1, 0, 0, 0);
    issue(1, 1, 0, 1, 0, 1, 3, 0, 0);
    idle(); idle(); idle(); idle();
    // lw x7, bubble, add x7, then consumer of x7 -> youngest producer wins
    issue(1, 0, 0, 0, 0, 1, 7, 1, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 1, 7, 0, 0);
    issue(1, 1, 7, 0, 0, 1, 8, 0, 0);
    idle(); idle(); idle(); idle();
    // lw x9, flush with dependent issue, then read x9
    issue(1, 0, 0, 0, 0, 1, 9, 1, 0);
    issue(1, 1, 9, 1, 9, 1, 10, 0, 1);
    issue(1, 1, 9, 0, 0, 1, 11, 0, 0);
    idle(); idle(); idle(); idle();
    // random traffic with a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      if (n == 200) begin
        do_reset();                          // reset mid-operation
        idle();
      end
    end
    // saturate the stall counter: 2**CNT_W + 3 load-use stalls
    do_reset();
    for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
      issue(1, 0, 0, 0, 0, 1, 5, 1, 0);
      issue(1, 1, 5, 0, 0, 1, 6, 0, 0);
    end
    idle(); idle();
    do_reset();
    idle(); idle();
    // drain: the monitor must have consumed every expectation
    @(negedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv_hazard_ctrl.md
Name: rv_hazard_ctrl

Overview:
- Parametrised hazard-control block for the in-order RISC-V pipeline: stall decision plus operand-forwarding select, replacing the ad-hoc reg_not_ready bitmap.
- Keeps a shadow pipeline of in-flight destination registers.
- Per issue slot, decides stall vs. forward vs. register-file read for rs1/rs2.
- Squashes younger entries on a taken branch and counts stall cycles.
- Sits beside the decode/issue stage; its selects drive the operand muxes feeding execute.

Parameters:
- REG_W, 5, register index width (2**REG_W architectural registers).
- DEPTH, 4, shadow stages tracked after issue (stage 1 = execute ... stage DEPTH = last stage before register-file write completes).
- ALU_AVAIL, 1, first stage at which a non-load result can be forwarded.
- LOAD_AVAIL, 2, first stage at which a load result can be forwarded; constraint ALU_AVAIL <= LOAD_AVAIL <= DEPTH.
- BR_STAGE, 2, stage at which flush is resolved; entries in stages 1..BR_STAGE-1 are younger and are squashed.
- CNT_W, 32, stall counter width.
- SEL_W, $clog2(DEPTH+1), derived forward-select width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  decode stage presents an instruction.
- issue_rs1e  in  1  rs1 used.
- issue_rs1  in  REG_W  rs1 index.
- issue_rs2e  in  1  rs2 used.
- issue_rs2  in  REG_W  rs2 index.
- issue_rde  in  1  instruction writes rd.
- issue_rd  in  REG_W  rd index.
- issue_is_load  in  1  instruction is a load.
- flush  in  1  taken branch resolved in BR_STAGE this cycle.
- issue_stall  out  1  combinational; hold decode/fetch, insert bubble.
- fwd_sel_rs1  out  SEL_W  0 = register file, k = forward from stage k.
- fwd_sel_rs2  out  SEL_W  same encoding as fwd_sel_rs1, for rs2.
- inflight_cnt  out  $clog2(DEPTH+1)  number of valid shadow entries.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Each shadow entry holds: valid, rd, avail (ALU_AVAIL or LOAD_AVAIL, set at issue).
- Every cycle entries shift from stage k to k+1; the stage-DEPTH entry retires. The register file is write-first, so a retired value is readable at issue the same cycle.
- Stage-1 load:
  - an issue that is valid, not stalled and not flushed loads {issue_rde && issue_rd!=0, issue_rd, avail};
  - otherwise stage 1 loads a bubble (valid=0).
- Hazard match for a source: the source is enabled, index != 0, and a valid entry has rd == index. The lowest stage index wins (youngest producer).
- For the winning entry at stage k:
  - if k >= avail, fwd_sel = k, no stall from this source;
  - else the source stalls.
- No match: fwd_sel = 0.
- issue_stall = issue_valid && !flush && (rs1 stalls || rs2 stalls).
- fwd_sel outputs are 0 whenever issue_stall or !issue_valid.
- Flush:
  - entries at stages 1..BR_STAGE-1 are invalidated at the clock edge, in addition to the normal shift;
  - the current issue is squashed (stage 1 gets a bubble);
  - issue_stall = 0 for that cycle;
  - entries at stage >= BR_STAGE shift normally.
- Stall: older entries keep shifting and stage 1 gets a bubble, so a load-use stall resolves after LOAD_AVAIL - ALU_AVAIL cycles.
- stall_cnt increments on every cycle with issue_stall=1 and saturates at all-ones.
- inflight_cnt is the registered population count of entry valids, updated each edge.
- Reset: all entries invalid; stall_cnt=0; inflight_cnt=0; combinational outputs become 0 because no entries are valid.
- Reset mid-operation discards all tracked producers without retiring them.

Decomposition:
- Package rv_pipe_pkg holds:
  - the shadow entry struct {valid, rd, avail};
  - the SEL encoding constant FWD_RF=0;
  - shared instruction-type constants (IS_ADD, IS_LOAD, IS_STORE) used by decoder and execute.
- One sub-module, rv_src_match:
  - combinational per-source priority search over the DEPTH entries;
  - returns {hit, stage, stall};
  - instantiated twice, once for rs1 and once for rs2.

Test Plan:
- add x5 then add x6,x5,x1 on the next cycle -> fwd_sel_rs1=1, issue_stall=0, stall_cnt stays 0.
- lw x5 then add x6,x5,x5 on the next cycle -> issue_stall=1 for exactly 1 cycle. The retry sees fwd_sel_rs1=fwd_sel_rs2=2 and stall_cnt=1.
- Write to x0 via rd=0, then an issue reading x0 -> no stall, fwd_sel=0, and no entry counted in inflight_cnt.
- Two producers of x7 at stages 1 (ALU) and 3 (load), consumer reads x7 -> fwd_sel_rs1=1, taking the youngest producer.
- lw x9 issued, flush asserted the next cycle alongside a dependent issue -> the stage-1 entry and the issue are squashed, issue_stall=0. The following issue reading x9 gets fwd_sel=0.
- Force 2**CNT_W+3 stall cycles with CNT_W=4 -> stall_cnt saturates at 15. Reset then returns stall_cnt and inflight_cnt to 0.
